host_reg_slave: RTL

- Parametrised host-bus register slave for the DUT side of the host_io-style bus (chip select, write strobe, address, bidirectional data).
- Generalises the fixed 16-bit, zero-wait bus in several ways:
  - configurable address/data width, register count and base address;
  - programmable wait states with a `ready` handshake;
  - per-register access modes: RW, RO, W1C;
  - address-decode error signalling.
- Sits between the testbench/host agent and the DUT's functional logic, which consumes `reg_q` and supplies status through `hw_in` and `hw_set`.

---
 rtl/host_reg_slave.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/host_reg_slave.sv
// Host-bus register slave: chip-select/strobe bus with programmable wait
// states, a ready handshake, per-register RW/RO/W1C access and decode errors.
module host_reg_slave #(
  parameter int                  AW          = 16,
  parameter int                  DW          = 16,
  parameter int                  NUM_REGS    = 8,
  parameter logic [AW-1:0]       BASE_ADDR   = 'h0100,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK    = '0,
  parameter logic [DW-1:0]       RESET_VAL   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs_n,
  input  logic                   wr_n,
  input  logic [AW-1:0]          address,
  inout  wire  [DW-1:0]          data,
  output logic                   ready,
  output logic                   decerr,
  output logic [NUM_REGS*DW-1:0] reg_q,
  output logic [NUM_REGS-1:0]    wr_pulse,
  input  logic [NUM_REGS*DW-1:0] hw_in,
  input  logic [NUM_REGS*DW-1:0] hw_set
);

  localparam int            IW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [AW:0]   NREG_X   = (AW+1)'(NUM_REGS);
  localparam logic [3:0]    CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              wr_n_reg;
  logic [DW-1:0]     wdata_reg;
  logic              hit_reg;
  logic [IW-1:0]     idx_reg;
  logic [DW-1:0]     rdata_reg;
  logic              data_oe_reg;
  logic [NUM_REGS-1:0] wr_pulse_reg;

  logic [AW-1:0]     dec_off;
  logic              dec_hit;
  logic [IW-1:0]     dec_idx;
  logic              sel_hit;
  logic [IW-1:0]     sel_idx;
  logic              sel_rd;
  logic              enter_access;
  logic              commit;
  logic [DW-1:0]     rd_src;

  logic [DW-1:0]     reg_arr   [NUM_REGS];
  logic [DW-1:0]     hw_in_arr [NUM_REGS];
  logic [DW-1:0]     set_arr   [NUM_REGS];
  logic [NUM_REGS-1:0] wr_sel;

  // Address decode: unsigned offset, addresses below the base never alias in.
  assign dec_off = address - BASE_ADDR;
  assign dec_hit = (address >= BASE_ADDR) && ({1'b0, dec_off} < NREG_X);
  assign dec_idx = dec_hit ? dec_off[IW-1:0] : '0;

  // With zero wait states ACCESS is entered straight from IDLE, so the live
  // decode must feed the read snapshot; otherwise the latched one does.
  assign sel_hit = (state_reg == IDLE) ? dec_hit : hit_reg;
  assign sel_idx = (state_reg == IDLE) ? dec_idx : idx_reg;
  assign sel_rd  = (state_reg == IDLE) ? wr_n    : wr_n_reg;

  assign enter_access = (state_next == ACCESS) && (state_reg != ACCESS);
  assign commit       = (state_reg == ACCESS) && !wr_n_reg && hit_reg && !RO_MASK[idx_reg];

  // Next-state logic for the bus transaction sequencer.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (!cs_n) begin
          if (WAIT_STATES > 0) begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end else begin
            state_next = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cs_n) begin
          state_next = IDLE;
        end else if (cnt_reg == 4'd0) begin
          state_next = ACCESS;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ACCESS:  state_next = HOLD;
      HOLD:    if (cs_n) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read value captured on entry to ACCESS; misses read as zero.
  always_comb begin
    rd_src = '0;
    if (sel_hit) begin
      rd_src = RO_MASK[sel_idx] ? hw_in_arr[sel_idx] : reg_arr[sel_idx];
    end
  end

  // Sequencer state, request latches, read snapshot and bus output enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      wr_n_reg     <= 1'b1;
      wdata_reg    <= '0;
      hit_reg      <= 1'b0;
      idx_reg      <= '0;
      rdata_reg    <= '0;
      data_oe_reg  <= 1'b0;
      wr_pulse_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      wr_pulse_reg <= wr_sel;
      if (state_reg == IDLE && !cs_n) begin
        wr_n_reg  <= wr_n;
        wdata_reg <= data;
        hit_reg   <= dec_hit;
        idx_reg   <= dec_idx;
      end
      if (enter_access) begin
        rdata_reg   <= rd_src;
        data_oe_reg <= sel_rd;
      end else if (state_reg == HOLD && cs_n) begin
        data_oe_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : gen_reg
      assign hw_in_arr[gi]          = hw_in[gi*DW +: DW];
      assign set_arr[gi]            = (W1C_MASK[gi] && !RO_MASK[gi]) ? hw_set[gi*DW +: DW] : '0;
      assign wr_sel[gi]             = commit && (idx_reg == IW'(gi));
      assign reg_q[gi*DW +: DW]     = reg_arr[gi];

      if (RO_MASK[gi]) begin : g_ro
        assign reg_arr[gi] = RESET_VAL;
      end else begin : g_rw
        logic [DW-1:0] q_reg;
        // Host write (plain or write-1-to-clear) plus sticky hardware set; set wins.
        always_ff @(posedge clk) begin
          if (reset) begin
            q_reg <= RESET_VAL;
          end else if (W1C_MASK[gi]) begin
            q_reg <= (wr_sel[gi] ? (q_reg & ~wdata_reg) : q_reg) | set_arr[gi];
          end else if (wr_sel[gi]) begin
            q_reg <= wdata_reg;
          end
        end
        assign reg_arr[gi] = q_reg;
      end
    end
  endgenerate

  assign ready    = (state_reg == ACCESS);
  assign decerr   = (state_reg == ACCESS) && !hit_reg;
  assign wr_pulse = wr_pulse_reg;
  assign data     = data_oe_reg ? rdata_reg : 'z;

endmodule
